rc_tdc_scheduler: RTL

- Time-shares one charge-time counter between NUM_CH RC sensor channels, round-robin.
- For each channel it runs the full measurement sequence: drive step_set, count until threshold or timeout, force a proportional discharge, then hand the count to the downstream resistance/BCD pipeline over a valid/ready handshake.
- Sits between the RC pads and the resistance calculator, replacing the single-channel charge/discharge control.

---
 rtl/rc_tdc_scheduler.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/rc_tdc_scheduler.sv
// Round-robin RC charge-time scheduler: one shared counter sequences
// charge, proportional discharge and a valid/ready result per channel.
module rc_tdc_scheduler #(
   parameter int               NUM_CH      = 4,
   parameter int               CNT_W       = 24,
   parameter logic [CNT_W-1:0] TIMEOUT     = 24'hFFFFFF,
   parameter int               DISCH_SHIFT = 1,
   parameter int               DISCH_MIN   = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [NUM_CH-1:0]         ch_mask,
   input  logic [NUM_CH-1:0]         step_input,
   output logic [NUM_CH-1:0]         step_set,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [CNT_W-1:0]          res_count,
   output logic [$clog2(NUM_CH)-1:0] res_ch,
   output logic                      res_ovf,
   output logic                      busy
);

   localparam int CH_W = $clog2(NUM_CH);
   localparam int WW   = CNT_W + DISCH_SHIFT;

   localparam logic [WW-1:0]    SAT  = WW'({CNT_W{1'b1}});
   localparam logic [CNT_W-1:0] DMIN = CNT_W'(DISCH_MIN);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      CHARGE,
      DISCHARGE
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_CH-1:0]   sync1_q, sync1_d;
   logic [NUM_CH-1:0]   sync2_q, sync2_d;
   logic [CH_W-1:0]     cur_q, cur_d;
   logic [CH_W-1:0]     last_q, last_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    dcnt_q, dcnt_d;
   logic [CNT_W-1:0]    target_q, target_d;
   logic [NUM_CH-1:0]   step_set_q, step_set_d;
   logic                res_valid_q, res_valid_d;
   logic [CNT_W-1:0]    res_count_q, res_count_d;
   logic [CH_W-1:0]     res_ch_q, res_ch_d;
   logic                res_ovf_q, res_ovf_d;
   logic                busy_q, busy_d;

   logic [CH_W-1:0]     nxt;
   logic [CNT_W-1:0]    cap;
   logic                hit;
   logic                tmo;
   logic                accept;
   logic                disch_done;
   logic                start;

   // First set mask bit strictly after l, wrapping; l itself is checked last.
   function automatic logic [CH_W-1:0] next_ch(
      input logic [NUM_CH-1:0] m,
      input logic [CH_W-1:0]   l
   );
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] ci;
      logic            found;
      int              idx;
      r     = l;
      found = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = (int'(l) + k) % NUM_CH;
         ci  = CH_W'(idx);
         if (!found && m[ci]) begin
            r     = ci;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] disch_target(
      input logic [CNT_W-1:0] c
   );
      logic [WW-1:0]    w;
      logic [CNT_W-1:0] t;
      w = WW'(c) << DISCH_SHIFT;
      if (w > SAT) t = {CNT_W{1'b1}};
      else         t = w[CNT_W-1:0];
      if (t < DMIN) t = DMIN;
      return t;
   endfunction

   always_comb begin
      sync1_d     = step_input;
      sync2_d     = sync1_q;
      state_d     = state_q;
      cur_d       = cur_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      dcnt_d      = dcnt_q;
      target_d    = target_q;
      step_set_d  = step_set_q;
      res_valid_d = res_valid_q & ~res_ready;
      res_count_d = res_count_q;
      res_ch_d    = res_ch_q;
      res_ovf_d   = res_ovf_q;

      nxt         = next_ch(ch_mask, last_q);
      hit         = sync2_q[cur_q];
      tmo         = cnt_q == TIMEOUT - ONE;
      cap         = hit ? cnt_q : TIMEOUT;
      accept      = ~res_valid_q | res_ready;
      disch_done  = dcnt_q == target_q - ONE;
      start       = enable & (|ch_mask);

      unique case (state_q)
         IDLE: begin
            if (start) state_d = SELECT;
         end
         SELECT: begin
            cnt_d      = '0;
            step_set_d = '0;
            if (|ch_mask) begin
               cur_d           = nxt;
               step_set_d[nxt] = 1'b1;
               state_d         = CHARGE;
            end else begin
               state_d = IDLE;
            end
         end
         CHARGE: begin
            if (hit || tmo) begin
               state_d     = DISCHARGE;
               step_set_d  = '0;
               res_valid_d = 1'b1;
               res_count_d = cap;
               res_ch_d    = cur_q;
               res_ovf_d   = ~hit;
               last_d      = cur_q;
               target_d    = disch_target(cap);
               dcnt_d      = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         DISCHARGE: begin
            step_set_d = '0;
            // Counter parks at target-1 until the result is taken.
            if (!disch_done) begin
               dcnt_d = dcnt_q + ONE;
            end else if (accept) begin
               state_d = start ? SELECT : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = state_d != IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sync1_q     <= '0;
         sync2_q     <= '0;
         cur_q       <= '0;
         last_q      <= CH_W'(NUM_CH - 1);
         cnt_q       <= '0;
         dcnt_q      <= '0;
         target_q    <= DMIN;
         step_set_q  <= '0;
         res_valid_q <= 1'b0;
         res_count_q <= '0;
         res_ch_q    <= '0;
         res_ovf_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         cur_q       <= cur_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         dcnt_q      <= dcnt_d;
         target_q    <= target_d;
         step_set_q  <= step_set_d;
         res_valid_q <= res_valid_d;
         res_count_q <= res_count_d;
         res_ch_q    <= res_ch_d;
         res_ovf_q   <= res_ovf_d;
         busy_q      <= busy_d;
      end
   end

   assign step_set  = step_set_q;
   assign res_valid = res_valid_q;
   assign res_count = res_count_q;
   assign res_ch    = res_ch_q;
   assign res_ovf   = res_ovf_q;
   assign busy      = busy_q;

endmodule
